mux_scan: RTL and testbench

Registered, parametrised N-way word multiplexer with a manual-select mode and an auto-scan mode. Auto-scan steps through enabled channels on a programmable dwell. It generalises the combinational 2/4/8-way 16-bit mux family to arbitrary width and channel count. It is the front end for time-multiplexed monitoring of register and bus values in the chapter-3+ sequential designs.

---
 rtl/mux_scan_pkg.sv | 12 +
 rtl/mux_scan_next.sv | 46 ++++
 rtl/mux_scan.sv | 167 ++++++++++++++++
 tb/tb_mux_scan.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux_scan slice: mode encodings and FSM states.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } scan_state_t;

endpackage

// File: rtl/mux_scan_next.sv
// Rotating priority encoder: finds the first set mask bit starting at (or just
// above) a start index, wrapping past the top channel back to channel 0.
module mux_scan_next #(
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_mask,
  input  logic [SEL_W-1:0]    i_start,
  input  logic                i_inclusive,
  output logic [SEL_W-1:0]    o_next,
  output logic                o_found,
  output logic                o_wrapped
);

  logic [31:0] w_startExt;

  assign w_startExt = 32'(i_start);

  // Walk the offsets in priority order; o_wrapped marks a hit that lies past the top channel.
  always_comb begin
    int                startNorm;
    int                sum;
    int                idx;
    logic [SEL_W-1:0]  idxSel;
    o_next    = '0;
    o_found   = 1'b0;
    o_wrapped = 1'b0;
    startNorm = (w_startExt < 32'(CHANNELS)) ? int'(w_startExt) : 0;
    sum       = 0;
    idx       = 0;
    idxSel    = '0;
    for (int o = 0; o <= CHANNELS; o++) begin
      if (!o_found && (i_inclusive ? (o < CHANNELS) : (o > 0))) begin
        sum    = startNorm + o;
        idx    = (sum >= CHANNELS) ? (sum - CHANNELS) : sum;
        idxSel = SEL_W'(idx);
        if (i_mask[idxSel]) begin
          o_found   = 1'b1;
          o_next    = idxSel;
          o_wrapped = (sum >= CHANNELS);
        end
      end
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Registered N-way word mux with manual select and auto-scan over enabled
// channels, each scanned channel held for dwell+1 cycles.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 8,
  parameter  int DWELL_W  = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       enable_mask,
  input  logic [DWELL_W-1:0]        dwell,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  output logic                      wrap
);

  scan_state_t       r_state;
  scan_state_t       w_stateNext;
  logic [SEL_W-1:0]  r_cur;
  logic [SEL_W-1:0]  w_curNext;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cntNext;
  logic [WIDTH-1:0]  r_out;
  logic [WIDTH-1:0]  w_outNext;
  logic [SEL_W-1:0]  r_outSel;
  logic [SEL_W-1:0]  w_outSelNext;
  logic              r_outValid;
  logic              w_outValidNext;
  logic              r_wrap;
  logic              w_wrapNext;
  logic              r_wrapPend;
  logic              w_wrapPendNext;

  logic [WIDTH-1:0]  w_words [CHANNELS];
  logic [31:0]       w_selExt;
  logic [31:0]       w_curExt;
  logic              w_selInRange;
  logic              w_curInRange;
  logic              w_curEnabled;
  logic [WIDTH-1:0]  w_selWord;
  logic [WIDTH-1:0]  w_curWord;
  logic              w_entering;
  logic [SEL_W-1:0]  w_searchStart;
  logic [SEL_W-1:0]  w_next;
  logic              w_found;
  logic              w_wrapped;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_words
    assign w_words[k] = in[k*WIDTH +: WIDTH];
  end

  assign w_selExt     = 32'(sel);
  assign w_curExt     = 32'(r_cur);
  assign w_selInRange = (w_selExt < 32'(CHANNELS));
  assign w_curInRange = (w_curExt < 32'(CHANNELS));
  assign w_curEnabled = w_curInRange && enable_mask[r_cur];
  assign w_selWord    = w_selInRange ? w_words[sel] : '0;
  assign w_curWord    = w_curInRange ? w_words[r_cur] : '0;

  // The first scan edge searches inclusively from sel; later advances search strictly above cur.
  assign w_entering    = (mode == MODE_SCAN) && (r_state == ST_MANUAL);
  assign w_searchStart = w_entering ? sel : r_cur;

  mux_scan_next #(
    .CHANNELS (CHANNELS)
  ) u_next (
    .i_mask      (enable_mask),
    .i_start     (w_searchStart),
    .i_inclusive (w_entering),
    .o_next      (w_next),
    .o_found     (w_found),
    .o_wrapped   (w_wrapped)
  );

  // State simply tracks the mode input sampled on each edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_MANUAL;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and datapath decisions; a wrap is owed at advance time and emitted with the first display of the new channel.
  always_comb begin
    w_stateNext    = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
    w_curNext      = r_cur;
    w_cntNext      = r_cnt;
    w_outNext      = r_out;
    w_outSelNext   = r_outSel;
    w_outValidNext = r_outValid;
    w_wrapNext     = 1'b0;
    w_wrapPendNext = r_wrapPend;
    if ((mode == MODE_MANUAL) || (r_state == ST_MANUAL)) begin
      w_cntNext      = '0;
      w_wrapPendNext = 1'b0;
      if (w_selInRange) begin
        w_outNext      = w_selWord;
        w_outSelNext   = sel;
        w_outValidNext = 1'b1;
      end else begin
        w_outValidNext = 1'b0;
      end
      if (w_entering && w_found) begin
        w_curNext = w_next;
      end else begin
        w_curNext = sel;
      end
    end else if (enable_mask == '0) begin
      w_outValidNext = 1'b0;
      w_cntNext      = '0;
      w_wrapPendNext = 1'b0;
    end else if (!w_curEnabled) begin
      w_outValidNext = 1'b0;
      w_cntNext      = '0;
      w_curNext      = w_next;
      w_wrapPendNext = r_wrapPend | w_wrapped;
    end else begin
      w_outNext      = w_curWord;
      w_outSelNext   = r_cur;
      w_outValidNext = 1'b1;
      w_wrapNext     = r_wrapPend;
      w_wrapPendNext = 1'b0;
      if (r_cnt >= dwell) begin
        w_curNext      = w_next;
        w_cntNext      = '0;
        w_wrapPendNext = w_wrapped;
      end else begin
        w_cntNext = r_cnt + DWELL_W'(1);
      end
    end
  end

  // Datapath and output registers, all cleared immediately by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cur      <= '0;
      r_cnt      <= '0;
      r_out      <= '0;
      r_outSel   <= '0;
      r_outValid <= 1'b0;
      r_wrap     <= 1'b0;
      r_wrapPend <= 1'b0;
    end else begin
      r_cur      <= w_curNext;
      r_cnt      <= w_cntNext;
      r_out      <= w_outNext;
      r_outSel   <= w_outSelNext;
      r_outValid <= w_outValidNext;
      r_wrap     <= w_wrapNext;
      r_wrapPend <= w_wrapPendNext;
    end
  end

  assign out       = r_out;
  assign out_sel   = r_outSel;
  assign out_valid = r_outValid;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan: directed scenarios plus randomized traffic
// compared against a behavioural model of the select/scan rules.
module tb_mux_scan;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 8;
  localparam int DWELL_W  = 8;
  localparam int SEL_W    = 3;

  logic                      clock = 1'b0;
  logic                      reset = 1'b0;
  logic [WIDTH-1:0]          chanData [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] in;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic [CHANNELS-1:0]       enableMask;
  logic [DWELL_W-1:0]        dwell;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          outSel;
  logic                      outValid;
  logic                      wrap;

  logic [WIDTH-1:0]          data6 [6];
  logic [6*WIDTH-1:0]        in6;
  logic [2:0]                sel6;
  logic [WIDTH-1:0]          out6;
  logic [2:0]                outSel6;
  logic                      outValid6;
  logic                      wrap6;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] mOut;
  int               mOutSel;
  int               mCur;
  int               mCnt;
  bit               mValid;
  bit               mWrap;
  bit               mOwed;
  bit               mScan;

  int fullSeq [11];
  int sparseSeq [14];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_pack
    assign in[k*WIDTH +: WIDTH] = chanData[k];
  end
  for (genvar k = 0; k < 6; k++) begin : g_pack6
    assign in6[k*WIDTH +: WIDTH] = data6[k];
  end

  mux_scan #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .DWELL_W  (DWELL_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in          (in),
    .sel         (sel),
    .mode        (mode),
    .enable_mask (enableMask),
    .dwell       (dwell),
    .out         (out),
    .out_sel     (outSel),
    .out_valid   (outValid),
    .wrap        (wrap)
  );

  mux_scan #(
    .WIDTH    (WIDTH),
    .CHANNELS (6),
    .DWELL_W  (DWELL_W)
  ) dut6 (
    .clock       (clock),
    .reset       (reset),
    .in          (in6),
    .sel         (sel6),
    .mode        (1'b0),
    .enable_mask (6'h3F),
    .dwell       (8'd0),
    .out         (out6),
    .out_sel     (outSel6),
    .out_valid   (outValid6),
    .wrap        (wrap6)
  );

  // 100 MHz-style free-running clock
  always #5 clock = ~clock;

  // Hard stop in case something upstream never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int findEnabled(input logic [CHANNELS-1:0] mask, input int start, input bit inclusive);
    int idx;
    for (int step = 0; step < CHANNELS; step++) begin
      idx = (start + step + (inclusive ? 0 : 1)) % CHANNELS;
      if (mask[idx[2:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mOut    = '0;
    mOutSel = 0;
    mCur    = 0;
    mCnt    = 0;
    mValid  = 1'b0;
    mWrap   = 1'b0;
    mOwed   = 1'b0;
    mScan   = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs currently applied.
  task automatic modelStep();
    int nxt;
    if (mode == 1'b0 || !mScan) begin
      mWrap   = 1'b0;
      mOwed   = 1'b0;
      mCnt    = 0;
      mOut    = chanData[sel];
      mOutSel = int'(sel);
      mValid  = 1'b1;
      if (mode) begin
        nxt  = findEnabled(enableMask, int'(sel), 1'b1);
        mCur = (nxt < 0) ? int'(sel) : nxt;
      end else begin
        mCur = int'(sel);
      end
    end else if (enableMask == '0) begin
      mValid = 1'b0;
      mCnt   = 0;
      mWrap  = 1'b0;
      mOwed  = 1'b0;
    end else if (!enableMask[mCur[2:0]]) begin
      mValid = 1'b0;
      mCnt   = 0;
      mWrap  = 1'b0;
      nxt    = findEnabled(enableMask, mCur, 1'b0);
      if (nxt <= mCur) mOwed = 1'b1;
      mCur   = nxt;
    end else begin
      mOut    = chanData[mCur[2:0]];
      mOutSel = mCur;
      mValid  = 1'b1;
      mWrap   = mOwed;
      mOwed   = 1'b0;
      if (mCnt >= int'(dwell)) begin
        nxt   = findEnabled(enableMask, mCur, 1'b0);
        mOwed = (nxt <= mCur);
        mCur  = nxt;
        mCnt  = 0;
      end else begin
        mCnt++;
      end
    end
    mScan = mode;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".out"},       32'(out),      32'(mOut));
    checkOutput({tag, ".out_sel"},   32'(outSel),   32'(mOutSel));
    checkOutput({tag, ".out_valid"}, 32'(outValid), 32'(mValid));
    checkOutput({tag, ".wrap"},      32'(wrap),     32'(mWrap));
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic applyStimulus(input string tag);
    modelStep();
    @(posedge clock);
    #1;
    checkAll(tag);
    @(negedge clock);
  endtask

  initial begin
    fullSeq   = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    sparseSeq = '{0, 0, 0, 0, 2, 2, 2, 5, 5, 5, 7, 7, 7, 0};
    for (int k = 0; k < CHANNELS; k++) chanData[k[2:0]] = 16'(k);
    for (int k = 0; k < 6; k++) data6[k[2:0]] = 16'(k);
    sel        = '0;
    sel6       = '0;
    mode       = 1'b0;
    enableMask = '1;
    dwell      = '0;

    #1 reset = 1'b1;
    modelReset();
    #2;
    checkAll("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int pass = 0; pass < 2; pass++) begin
      for (int s = 0; s < CHANNELS; s++) begin
        sel = 3'(s);
        applyStimulus("sweep");
        checkOutput("sweep.direct", 32'(out), 32'(s));
      end
    end

    sel        = 3'd0;
    enableMask = 8'hFF;
    dwell      = 8'd0;
    mode       = 1'b1;
    for (int i = 0; i < 11; i++) begin
      applyStimulus("full");
      checkOutput("full.seq",  32'(outSel), 32'(fullSeq[i]));
      checkOutput("full.wrap", 32'(wrap),   32'(i == 9));
    end

    mode = 1'b0;
    applyStimulus("toManual");

    enableMask = 8'b1010_0101;
    dwell      = 8'd2;
    sel        = 3'd0;
    mode       = 1'b1;
    for (int i = 0; i < 14; i++) begin
      applyStimulus("sparse");
      checkOutput("sparse.seq",  32'(outSel), 32'(sparseSeq[i]));
      checkOutput("sparse.wrap", 32'(wrap),   32'(i == 13));
    end

    for (int n = 0; n < 40 && mOutSel != 2; n++) applyStimulus("seek2");
    checkOutput("seek2.reached", 32'(outSel), 32'd2);
    enableMask = 8'b1010_0001;
    applyStimulus("maskDrop");
    checkOutput("maskDrop.valid", 32'(outValid), 32'd0);
    applyStimulus("maskNext");
    checkOutput("maskNext.sel", 32'(outSel), 32'd5);
    checkOutput("maskNext.out", 32'(out),    32'h0005);
    enableMask = '0;
    applyStimulus("maskZero");
    checkOutput("maskZero.valid", 32'(outValid), 32'd0);
    checkOutput("maskZero.hold",  32'(out),      32'h0005);

    mode = 1'b0;
    applyStimulus("toManual2");
    mode       = 1'b1;
    sel        = 3'd3;
    enableMask = 8'hFF;
    dwell      = 8'd1;
    for (int i = 0; i < 5; i++) applyStimulus("preReset");
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncReset.out",       32'(out),      32'd0);
    checkOutput("asyncReset.out_sel",   32'(outSel),   32'd0);
    checkOutput("asyncReset.out_valid", 32'(outValid), 32'd0);
    checkOutput("asyncReset.wrap",      32'(wrap),     32'd0);
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    applyStimulus("postReset1");
    checkOutput("postReset1.sel", 32'(outSel), 32'd3);
    applyStimulus("postReset2");
    checkOutput("postReset2.sel", 32'(outSel), 32'd3);
    applyStimulus("postReset3");
    checkOutput("postReset3.sel", 32'(outSel), 32'd3);
    applyStimulus("postReset4");
    checkOutput("postReset4.sel", 32'(outSel), 32'd4);

    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < CHANNELS; k++) chanData[k[2:0]] = 16'($urandom);
      sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 14) == 0) begin
        case ($urandom_range(0, 3))
          0:       enableMask = '0;
          1:       enableMask = 8'(1 << $urandom_range(0, 7));
          default: enableMask = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 14) == 0) dwell = 8'($urandom_range(0, 3));
      applyStimulus("rand");
    end

    sel6 = 3'd5;
    @(posedge clock);
    #1;
    checkOutput("range.in.out",   32'(out6),      32'h0005);
    checkOutput("range.in.sel",   32'(outSel6),   32'd5);
    checkOutput("range.in.valid", 32'(outValid6), 32'd1);
    @(negedge clock);
    sel6 = 3'd7;
    @(posedge clock);
    #1;
    checkOutput("range.out7.valid", 32'(outValid6), 32'd0);
    checkOutput("range.out7.hold",  32'(out6),      32'h0005);
    checkOutput("range.out7.sel",   32'(outSel6),   32'd5);
    @(negedge clock);
    sel6 = 3'd6;
    @(posedge clock);
    #1;
    checkOutput("range.out6.valid", 32'(outValid6), 32'd0);
    checkOutput("range.out6.hold",  32'(out6),      32'h0005);
    @(negedge clock);
    sel6 = 3'd2;
    @(posedge clock);
    #1;
    checkOutput("range.back.out",   32'(out6),      32'h0002);
    checkOutput("range.back.valid", 32'(outValid6), 32'd1);
    checkOutput("range.back.wrap",  32'(wrap6),     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
